// File: rtl/cpu54_pkg.sv
// Shared CPU-54 datapath widths, register/address types and a small match helper.
package cpu54_pkg;

    localparam int unsigned REG_W    = 32;
    localparam int unsigned RADDR_W  = 5;
    localparam int unsigned NUM_REGS = 32;

    typedef logic [REG_W-1:0]    reg_t;
    typedef logic [RADDR_W-1:0]  raddr_t;
    typedef logic [NUM_REGS-1:0] pend_t;

    function automatic logic idx_hit(input logic v, input raddr_t a, input raddr_t b);
        return v && (a == b);
    endfunction

endpackage

// File: rtl/operand_fetch_if.sv
// Decode, register-file, writeback and execute signals of the operand-fetch stage.
// slave = operand_fetch itself, master = the surrounding pipeline.
interface operand_fetch_if;
    import cpu54_pkg::*;

    logic   id_valid;
    logic   id_ready;
    raddr_t id_rsc;
    raddr_t id_rtc;
    logic   id_use_rs;
    logic   id_use_rt;
    logic   id_wr;
    raddr_t id_rdc;

    raddr_t rf_rsc;
    raddr_t rf_rtc;
    reg_t   rf_rs;
    reg_t   rf_rt;

    logic   wb_valid;
    raddr_t wb_rdc;
    reg_t   wb_data;

    logic   ex_valid;
    logic   ex_ready;
    reg_t   ex_rs;
    reg_t   ex_rt;
    raddr_t ex_rdc;
    logic   ex_wr;

    logic   sb_err;

    modport slave (
        input  id_valid, id_rsc, id_rtc, id_use_rs, id_use_rt, id_wr, id_rdc,
        input  rf_rs, rf_rt, wb_valid, wb_rdc, wb_data, ex_ready,
        output id_ready, rf_rsc, rf_rtc, ex_valid, ex_rs, ex_rt, ex_rdc, ex_wr, sb_err
    );

    modport master (
        output id_valid, id_rsc, id_rtc, id_use_rs, id_use_rt, id_wr, id_rdc,
        output rf_rs, rf_rt, wb_valid, wb_rdc, wb_data, ex_ready,
        input  id_ready, rf_rsc, rf_rtc, ex_valid, ex_rs, ex_rt, ex_rdc, ex_wr, sb_err
    );

endinterface

// File: rtl/of_scoreboard.sv
// 32-entry pending-write scoreboard: set on issue, clear on writeback, three query ports,
// sticky error on writeback to a register that was not pending. Entry 0 is always clear.
module of_scoreboard
    import cpu54_pkg::*;
(
    input  logic   clk_i,
    input  logic   rst_i,
    input  logic   set_i,
    input  raddr_t set_idx_i,
    input  logic   clr_i,
    input  raddr_t clr_idx_i,
    input  raddr_t qa_idx_i,
    input  raddr_t qb_idx_i,
    input  raddr_t qc_idx_i,
    output logic   qa_o,
    output logic   qb_o,
    output logic   qc_o,
    output logic   err_o
);

    pend_t pend_q, pend_d;
    logic  err_q, err_d;

    // Set is applied after clear so a new writer of the retiring register stays pending.
    always_comb begin
        pend_d = pend_q;
        err_d  = err_q;
        if (clr_i && (clr_idx_i != '0)) begin
            if (pend_q[clr_idx_i]) pend_d[clr_idx_i] = 1'b0;
            else                   err_d             = 1'b1;
        end
        if (set_i) pend_d[set_idx_i] = 1'b1;
        pend_d[0] = 1'b0;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pend_q <= '0;
            err_q  <= 1'b0;
        end else begin
            pend_q <= pend_d;
            err_q  <= err_d;
        end
    end

    assign qa_o  = pend_q[qa_idx_i];
    assign qb_o  = pend_q[qb_idx_i];
    assign qc_o  = pend_q[qc_idx_i];
    assign err_o = err_q;

endmodule

// File: rtl/operand_fetch.sv
// CPU-54 operand-read stage: RAW/WAW hazard stall, operand select and execute-side register.
// Optional writeback-to-operand forwarding is enabled with `define OF_BYPASS_EN.
module operand_fetch
    import cpu54_pkg::*;
(
    input  logic           OF_clk,
    input  logic           OF_rst,
    operand_fetch_if.slave bus
);

    logic   rs_pend, rt_pend, rd_pend;
    logic   rs_byp, rt_byp;
    logic   src_hz, waw_hz, slot_free, accept;
    reg_t   rs_sel, rt_sel;

    logic   ex_valid_q, ex_valid_d;
    reg_t   ex_rs_q, ex_rs_d;
    reg_t   ex_rt_q, ex_rt_d;
    raddr_t ex_rdc_q, ex_rdc_d;
    logic   ex_wr_q, ex_wr_d;

    of_scoreboard u_sb (
        .clk_i     (OF_clk),
        .rst_i     (OF_rst),
        .set_i     (accept && bus.id_wr && (bus.id_rdc != '0)),
        .set_idx_i (bus.id_rdc),
        .clr_i     (bus.wb_valid),
        .clr_idx_i (bus.wb_rdc),
        .qa_idx_i  (bus.id_rsc),
        .qb_idx_i  (bus.id_rtc),
        .qc_idx_i  (bus.id_rdc),
        .qa_o      (rs_pend),
        .qb_o      (rt_pend),
        .qc_o      (rd_pend),
        .err_o     (bus.sb_err)
    );

`ifdef OF_BYPASS_EN
    assign rs_byp = idx_hit(bus.wb_valid, bus.wb_rdc, bus.id_rsc);
    assign rt_byp = idx_hit(bus.wb_valid, bus.wb_rdc, bus.id_rtc);
`else
    logic unused_wb_data;
    assign rs_byp         = 1'b0;
    assign rt_byp         = 1'b0;
    assign unused_wb_data = ^bus.wb_data;
`endif

    assign src_hz = (bus.id_use_rs && (bus.id_rsc != '0) && rs_pend && !rs_byp)
                 || (bus.id_use_rt && (bus.id_rtc != '0) && rt_pend && !rt_byp);
    assign waw_hz = bus.id_wr && (bus.id_rdc != '0) && rd_pend
                 && !idx_hit(bus.wb_valid, bus.wb_rdc, bus.id_rdc);

    assign slot_free    = !ex_valid_q || bus.ex_ready;
    assign bus.id_ready = slot_free && !src_hz && !waw_hz;
    assign accept       = bus.id_valid && bus.id_ready;

    assign bus.rf_rsc = bus.id_rsc;
    assign bus.rf_rtc = bus.id_rtc;

    always_comb begin
        rs_sel = bus.rf_rs;
        rt_sel = bus.rf_rt;
        if (rs_byp) rs_sel = bus.wb_data;
        if (rt_byp) rt_sel = bus.wb_data;
        if (bus.id_rsc == '0) rs_sel = '0;
        if (bus.id_rtc == '0) rt_sel = '0;
    end

    always_comb begin
        ex_valid_d = ex_valid_q;
        ex_rs_d    = ex_rs_q;
        ex_rt_d    = ex_rt_q;
        ex_rdc_d   = ex_rdc_q;
        ex_wr_d    = ex_wr_q;
        if (accept) begin
            ex_valid_d = 1'b1;
            ex_rs_d    = rs_sel;
            ex_rt_d    = rt_sel;
            ex_rdc_d   = bus.id_rdc;
            ex_wr_d    = bus.id_wr;
        end else if (bus.ex_ready) begin
            ex_valid_d = 1'b0;
        end
    end

    always_ff @(posedge OF_clk or posedge OF_rst) begin
        if (OF_rst) begin
            ex_valid_q <= 1'b0;
            ex_rs_q    <= '0;
            ex_rt_q    <= '0;
            ex_rdc_q   <= '0;
            ex_wr_q    <= 1'b0;
        end else begin
            ex_valid_q <= ex_valid_d;
            ex_rs_q    <= ex_rs_d;
            ex_rt_q    <= ex_rt_d;
            ex_rdc_q   <= ex_rdc_d;
            ex_wr_q    <= ex_wr_d;
        end
    end

    assign bus.ex_valid = ex_valid_q;
    assign bus.ex_rs    = ex_rs_q;
    assign bus.ex_rt    = ex_rt_q;
    assign bus.ex_rdc   = ex_rdc_q;
    assign bus.ex_wr    = ex_wr_q;

endmodule
